mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-master arbiter in front of a single-ported data RAM. Master 0 is the CPU
// data port and master 1 is the loader/DMA port. A request is granted
// combinationally in the cycle it is presented. The winner's fields are driven
// onto the RAM port in that same cycle. Load data returns one cycle later, and
// a one-entry read tag steers it back to the master that issued the load.
//
// Arbitration:
//   - From idle, a lone requester wins.
//   - From idle with both requesting, the master not served last wins.
//     Master 0 wins the first tie after reset.
//   - While one master owns the port, it keeps winning for up to BURST_MAX
//     consecutive grants while the other master also requests. It then hands
//     the port to the other master.
//
// Parameters:
//   BURST_MAX    max consecutive grants to one master while the other
//                requests (1..15)
//
// Optional feature (compile-time macro):
//   MEM_ARB_MISALIGN_EN  When defined, a misaligned half or word request is
//                        granted and flagged with mX_err for one cycle. It
//                        does not access the RAM and counts as a grant for
//                        arbitration. When undefined, misaligned requests go
//                        to the RAM unchanged and mX_err is tied to 0.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-low reset
//   mX_req/we/uen/size/addr/wdata   request from master X (held until gnt)
//   mX_gnt                      request accepted this cycle
//   mX_rvalid, mX_rdata         load response, one cycle after the grant
//   mX_err                      request rejected as misaligned
//   ram_w_en/u_en/addr/size/d_in    RAM data-port command
//   ram_d_out                   registered RAM read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_uen,
    input  logic [1:0]  m0_size,
    input  logic [13:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_uen,
    input  logic [1:0]  m1_size,
    input  logic [13:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        ram_w_en,
    output logic        ram_u_en,
    output logic [13:0] ram_addr,
    output logic [1:0]  ram_size,
    output logic [31:0] ram_d_in,
    input  logic [31:0] ram_d_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_CAP = 4'(BURST_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  w_cnt_sat;
    logic        r_last;        // 1: master 1 was served last
    logic        w_last_nxt;
    logic        r_tag_vld;     // a load was issued last cycle
    logic        r_tag_id;      // issuer of that load
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_live0;
    logic        w_live1;
    logic        w_err0;
    logic        w_err1;
    logic        w_issue;

    assign w_cnt_sat = (r_cnt < BURST_CAP) ? r_cnt + 4'd1 : BURST_CAP;

    // Arbitration and next-state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
        w_last_nxt  = r_last;

        case (r_state)
            OWN0: begin
                if (m0_req && (!m1_req || r_cnt < BURST_CAP)) w_gnt0 = 1'b1;
                else if (m1_req)                              w_gnt1 = 1'b1;
            end
            OWN1: begin
                if (m1_req && (!m0_req || r_cnt < BURST_CAP)) w_gnt1 = 1'b1;
                else if (m0_req)                              w_gnt0 = 1'b1;
            end
            default: begin
                // Idle tie goes to the master that was not served last.
                if (m0_req && m1_req) begin
                    w_gnt0 = r_last;
                    w_gnt1 = !r_last;
                end else begin
                    w_gnt0 = m0_req;
                    w_gnt1 = m1_req;
                end
            end
        endcase

        // A run continues only when the owner wins again; any hand-over restarts it at 1.
        if (w_gnt0) begin
            w_state_nxt = OWN0;
            w_last_nxt  = 1'b0;
            w_cnt_nxt   = (r_state == OWN0) ? w_cnt_sat : 4'd1;
        end else if (w_gnt1) begin
            w_state_nxt = OWN1;
            w_last_nxt  = 1'b1;
            w_cnt_nxt   = (r_state == OWN1) ? w_cnt_sat : 4'd1;
        end
    end

    // Reset forces grants low at once, even while a master is requesting.
    assign w_live0 = w_gnt0 & reset;
    assign w_live1 = w_gnt1 & reset;

`ifdef MEM_ARB_MISALIGN_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == 2'b01) && lo[0]) || ((size == 2'b10) && (lo != 2'b00));
    endfunction

    assign w_err0 = w_live0 & misaligned(m0_size, m0_addr[1:0]);
    assign w_err1 = w_live1 & misaligned(m1_size, m1_addr[1:0]);
`else
    assign w_err0 = 1'b0;
    assign w_err1 = 1'b0;
`endif

    // A rejected request still counts as a grant but never reaches the RAM.
    assign w_issue = (w_live0 & ~w_err0) | (w_live1 & ~w_err1);

    always_comb begin
        ram_w_en = 1'b0;
        ram_u_en = 1'b0;
        ram_addr = '0;
        ram_size = '0;
        ram_d_in = '0;
        if (w_issue) begin
            if (w_live1) begin
                ram_w_en = m1_we;
                ram_u_en = m1_uen;
                ram_addr = m1_addr;
                ram_size = m1_size;
                ram_d_in = m1_wdata;
            end else begin
                ram_w_en = m0_we;
                ram_u_en = m0_uen;
                ram_addr = m0_addr;
                ram_size = m0_size;
                ram_d_in = m0_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_last    <= 1'b1;
            r_tag_vld <= 1'b0;
            r_tag_id  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_tag_vld <= w_issue & ~ram_w_en;
            r_tag_id  <= w_live1;
        end
    end

    assign m0_gnt    = w_live0;
    assign m1_gnt    = w_live1;
    assign m0_err    = w_err0;
    assign m1_err    = w_err1;
    assign m0_rvalid = r_tag_vld & ~r_tag_id;
    assign m1_rvalid = r_tag_vld &  r_tag_id;
    assign m0_rdata  = m0_rvalid ? ram_d_out : 32'd0;
    assign m1_rdata  = m1_rvalid ? ram_d_out : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter. It contains:
//   - a RAM model driven by the DUT's ram_* port;
//   - a byte-level reference memory updated from granted stimulus;
//   - a run-length arbitration model;
//   - a scoreboard queue of expected load responses, drained by a monitor.
module tb_mem_arbiter;

    localparam int BM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req, m0_we, m0_uen, m1_req, m1_we, m1_uen;
    logic [1:0]  m0_size, m1_size;
    logic [13:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_w_en, ram_u_en;
    logic [13:0] ram_addr;
    logic [1:0]  ram_size;
    logic [31:0] ram_d_in;
    logic [31:0] ram_d_out = 32'd0;

    always #5 clk = ~clk;

    mem_arbiter #(.BURST_MAX(BM)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_uen(m0_uen), .m0_size(m0_size),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_uen(m1_uen), .m1_size(m1_size),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_w_en(ram_w_en), .ram_u_en(ram_u_en), .ram_addr(ram_addr),
        .ram_size(ram_size), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic        uen;
        logic [1:0]  size;
        logic [13:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        int          id;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] last_rd0 = 32'd0;
    logic [31:0] last_rd1 = 32'd0;

    // Arbitration model: who was served last, how many times in a row, and
    // whether the previous cycle granted anyone at all.
    int m_last = 1;
    int m_run  = 0;
    bit m_prev = 1'b0;

    logic [7:0] ram_mem [int];
    logic [7:0] ref_mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [7:0] ram_byte(input int a);
        return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // RAM-side lane extraction for the RAM model.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uen);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   return uen ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uen ? {16'd0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // RAM model: writes at the grant edge, registered read data.
    always @(posedge clk) begin : ram_model
        int          base;
        logic [31:0] wv;
        logic [31:0] ld;
        logic [3:0]  be;
        base = {18'd0, ram_addr[13:2], 2'b00};
        if (ram_w_en) begin
            case (ram_size)
                2'b00:   begin be = 4'b0001 << ram_addr[1:0]; ld = {4{ram_d_in[7:0]}}; end
                2'b01:   begin be = ram_addr[1] ? 4'b1100 : 4'b0011; ld = {2{ram_d_in[15:0]}}; end
                default: begin be = 4'b1111; ld = ram_d_in; end
            endcase
            for (int i = 0; i < 4; i++) if (be[i]) ram_mem[base + i] = ld[8*i +: 8];
        end else begin
            for (int i = 0; i < 4; i++) wv[8*i +: 8] = ram_byte(base + i);
            ram_d_out <= fmt_load(wv, ram_addr[1:0], ram_size, ram_u_en);
        end
    end

    // Reference memory: a plain byte array, addressed by naturally aligned base.
    function automatic logic [31:0] ref_load(input logic [13:0] addr, input logic [1:0] size, input logic uen);
        int          n;
        int          base;
        logic [31:0] v;
        n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        base = int'(addr) & ~(n - 1);
        v    = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(base + i);
        if (n < 4 && !uen && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic ref_store(input logic [13:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n;
        int base;
        n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        base = int'(addr) & ~(n - 1);
        for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
    endtask

    function automatic logic misal(input logic [1:0] size, input logic [13:0] addr);
`ifdef MEM_ARB_MISALIGN_EN
        return ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    // Winner prediction from run-length rules: -1 none, 0/1 master.
    function automatic int predict(input logic r0, input logic r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        if (!m_prev)    return 1 - m_last;
        return (m_run < BM) ? m_last : 1 - m_last;
    endfunction

    task automatic model_update(input int w);
        if (w < 0) begin
            m_prev = 1'b0;
            m_run  = 0;
        end else begin
            if (m_prev && w == m_last) m_run = (m_run < BM) ? m_run + 1 : BM;
            else                       m_run = 1;
            m_last = w;
            m_prev = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_run  = 0;
        m_prev = 1'b0;
    endtask

    function automatic mreq_t idle_req();
        mreq_t r;
        r = '{req: 1'b0, we: 1'b0, uen: 1'b0, size: 2'b00, addr: 14'd0, wdata: 32'd0};
        return r;
    endfunction

    function automatic mreq_t mk(input logic we, input logic uen, input logic [1:0] size,
                                 input logic [13:0] addr, input logic [31:0] wdata);
        mreq_t r;
        r = '{req: 1'b1, we: we, uen: uen, size: size, addr: addr, wdata: wdata};
        return r;
    endfunction

    function automatic mreq_t rand_req();
        logic [1:0]  sz;
        logic [13:0] a;
        sz = 2'($urandom_range(0, 2));
        a  = 14'($urandom_range(0, 63));
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
        return mk(1'($urandom), 1'($urandom), sz, a, $urandom);
    endfunction

    task automatic drive(input mreq_t a, input mreq_t b);
        m0_req = a.req; m0_we = a.we; m0_uen = a.uen; m0_size = a.size; m0_addr = a.addr; m0_wdata = a.wdata;
        m1_req = b.req; m1_we = b.we; m1_uen = b.uen; m1_size = b.size; m1_addr = b.addr; m1_wdata = b.wdata;
    endtask

    // One bus cycle: entered just after a rising edge, checks grant and RAM
    // command on the falling edge, queues the expected load response.
    task automatic do_cycle(input mreq_t a, input mreq_t b, output int w);
        mreq_t s;
        logic  e;
        exp_t  x;
        drive(a, b);
        @(negedge clk);
        w = predict(a.req, b.req);
        check("gnt0", {31'd0, m0_gnt}, {31'd0, w == 0});
        check("gnt1", {31'd0, m1_gnt}, {31'd0, w == 1});
        if (w >= 0) begin
            s = (w == 0) ? a : b;
            e = misal(s.size, s.addr);
            check("err0", {31'd0, m0_err}, {31'd0, (w == 0) && e});
            check("err1", {31'd0, m1_err}, {31'd0, (w == 1) && e});
            check("ram_w_en", {31'd0, ram_w_en}, {31'd0, s.we && !e});
            check("ram_addr", {18'd0, ram_addr}, e ? 32'd0 : {18'd0, s.addr});
            if (!e) begin
                check("ram_size", {30'd0, ram_size}, {30'd0, s.size});
                if (s.we) begin
                    check("ram_d_in", ram_d_in, s.wdata);
                    ref_store(s.addr, s.size, s.wdata);
                end else begin
                    check("ram_u_en", {31'd0, ram_u_en}, {31'd0, s.uen});
                    x = '{id: w, cyc: cyc, data: ref_load(s.addr, s.size, s.uen)};
                    sb_q.push_back(x);
                end
            end
        end else begin
            check("idle_ram_w_en", {31'd0, ram_w_en}, 32'd0);
            check("idle_ram_addr", {18'd0, ram_addr}, 32'd0);
        end
        model_update(w);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        int w;
        do_cycle(idle_req(), idle_req(), w);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(idle_req(), idle_req());
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every load response must match the head of the scoreboard and
    // appear exactly one cycle after its grant.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (!m0_rvalid) check("rdata0_quiet", m0_rdata, 32'd0);
        if (!m1_rvalid) check("rdata1_quiet", m1_rdata, 32'd0);
        if (m0_rvalid || m1_rvalid) begin
            if (m0_rvalid && m1_rvalid) check("rvalid_both", 32'd1, 32'd0);
            if (sb_q.size() == 0 || sb_q[0].cyc != cyc - 1) begin
                check("rvalid_unexpected", {31'd0, m1_rvalid}, 32'hFFFF_FFFF);
            end else begin
                x = sb_q.pop_front();
                check("rvalid_id", {31'd0, m1_rvalid}, x.id);
                check("rdata", (x.id == 1) ? m1_rdata : m0_rdata, x.data);
                if (x.id == 1) last_rd1 <= m1_rdata;
                else           last_rd0 <= m0_rdata;
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc == cyc - 1) begin
            x = sb_q.pop_front();
            check("rvalid_missing", 32'd0, 32'd1);
        end
    end

    initial begin : stim
        int    w;
        mreq_t p0;
        mreq_t p1;

        // Reset state with a store request pending: nothing may leak out.
        drive(mk(1'b1, 1'b0, 2'b10, 14'h0010, 32'h1234_5678), idle_req());
        @(negedge clk);
        check("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
        check("rst_ram_w_en", {31'd0, ram_w_en}, 32'd0);
        check("rst_ram_addr", {18'd0, ram_addr}, 32'd0);
        check("rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        check("rst_err0", {31'd0, m0_err}, 32'd0);
        drive(idle_req(), idle_req());
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Word load returns the stored word one cycle after its grant.
        do_cycle(mk(1'b1, 1'b0, 2'b10, 14'h0010, 32'hDEAD_BEEF), idle_req(), w);
        do_cycle(mk(1'b0, 1'b0, 2'b10, 14'h0010, 32'd0), idle_req(), w);
        idle_cycle();
        check("word_load", last_rd0, 32'hDEAD_BEEF);

        // Store from master 1 is visible to master 0's next-cycle load.
        do_cycle(idle_req(), mk(1'b1, 1'b0, 2'b10, 14'h0020, 32'hCAFE_F00D), w);
        do_cycle(mk(1'b0, 1'b0, 2'b10, 14'h0020, 32'd0), idle_req(), w);
        idle_cycle();
        check("cross_master", last_rd0, 32'hCAFE_F00D);

        // Byte store then unsigned/signed byte loads.
        do_cycle(mk(1'b1, 1'b0, 2'b00, 14'h0005, 32'h0000_00AB), idle_req(), w);
        do_cycle(mk(1'b0, 1'b1, 2'b00, 14'h0005, 32'd0), idle_req(), w);
        idle_cycle();
        check("byte_unsigned", last_rd0, 32'h0000_00AB);
        do_cycle(mk(1'b1, 1'b0, 2'b00, 14'h0005, 32'h0000_0080), idle_req(), w);
        do_cycle(mk(1'b0, 1'b0, 2'b00, 14'h0005, 32'd0), idle_req(), w);
        idle_cycle();
        check("byte_signed", last_rd0, 32'hFFFF_FF80);

        // Continuous loads from both masters after reset: m0 x4, m1 x4, m0 x4.
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            do_cycle(mk(1'b0, 1'b0, 2'b10, 14'(4 * k), 32'd0),
                     mk(1'b0, 1'b0, 2'b10, 14'(64 + 4 * k), 32'd0), w);
            check("burst_pattern", w, (k >= 4 && k < 8) ? 32'd1 : 32'd0);
        end
        idle_cycle();

        // Misaligned half load: rejected with err, or passed to RAM, by build.
        do_cycle(mk(1'b0, 1'b1, 2'b01, 14'h0003, 32'd0), idle_req(), w);
`ifdef MEM_ARB_MISALIGN_EN
        check("misal_err", {31'd0, m0_err}, 32'd1);
`else
        check("misal_err", {31'd0, m0_err}, 32'd0);
`endif
        idle_cycle();

        // Load granted, then reset before the next edge: no response survives.
        drive(mk(1'b0, 1'b0, 2'b10, 14'h0010, 32'd0), idle_req());
        @(negedge clk);
        check("pre_rst_gnt0", {31'd0, m0_gnt}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_kills_gnt0", {31'd0, m0_gnt}, 32'd0);
        drive(idle_req(), idle_req());
        @(posedge clk);
        #1;
        check("rst_no_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_cycle(mk(1'b0, 1'b0, 2'b10, 14'h0030, 32'd0), mk(1'b0, 1'b0, 2'b10, 14'h0034, 32'd0), w);
        check("post_rst_tie", w, 32'd0);
        idle_cycle();

        // Randomised traffic; each master holds its request until granted.
        p0 = idle_req();
        p1 = idle_req();
        for (int n = 0; n < 3000; n++) begin
            if (!p0.req && $urandom_range(0, 3) != 0) p0 = rand_req();
            if (!p1.req && $urandom_range(0, 3) != 0) p1 = rand_req();
            do_cycle(p0, p1, w);
            if (w == 0) p0 = idle_req();
            if (w == 1) p1 = idle_req();
        end
        idle_cycle();
        idle_cycle();
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
